// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - decode-stage handshake and ID/EX control bundle
interface pipelined_control_unit_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                stall;
  logic                flush_in;
  logic [6:0]          EX_signals;
  logic [3:0]          MEM_signals;
  logic [2:0]          WB_signals;
  logic                ctrl_valid;
  logic                imm_fetch;
  logic                imm_capture;
  logic                illegal_op;

  modport master (
    output opcode, instr_valid, stall, flush_in,
    input  EX_signals, MEM_signals, WB_signals, ctrl_valid, imm_fetch, imm_capture, illegal_op
  );

  modport slave (
    input  opcode, instr_valid, stall, flush_in,
    output EX_signals, MEM_signals, WB_signals, ctrl_valid, imm_fetch, imm_capture, illegal_op
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered decode control unit with LDM sequencing FSM
// Optional illegal-opcode trap state enabled by defining ILLEGAL_TRAP_EN.
module pipelined_control_unit #(
  parameter int         OPCODE_W = 6,
  parameter logic [5:0] OP_NOP   = 6'b000001,
  parameter logic [5:0] OP_NOT   = 6'b000100,
  parameter logic [5:0] OP_ADD   = 6'b001011,
  parameter logic [5:0] OP_STD   = 6'b000010,
  parameter logic [5:0] OP_LDM   = 6'b111111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam logic [OPCODE_W-1:0] NOP_W = OPCODE_W'(OP_NOP);
  localparam logic [OPCODE_W-1:0] NOT_W = OPCODE_W'(OP_NOT);
  localparam logic [OPCODE_W-1:0] ADD_W = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] STD_W = OPCODE_W'(OP_STD);
  localparam logic [OPCODE_W-1:0] LDM_W = OPCODE_W'(OP_LDM);

  // Control row layout: {EX[6:0], MEM[3:0], WB[2:0]}
  localparam logic [13:0] ROW_NOT = {7'b0001101, 4'b0000, 3'b101};
  localparam logic [13:0] ROW_ADD = {7'b0010101, 4'b0000, 3'b101};
  localparam logic [13:0] ROW_STD = {7'b0000000, 4'b0110, 3'b000};
  localparam logic [13:0] ROW_LDM = {7'b0000000, 4'b1000, 3'b110};

  typedef enum logic [1:0] {
    S_DECODE   = 2'd0,
    S_IMM_WAIT = 2'd1
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP   = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] row_q, row_d;
  logic [13:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic        cap_q, cap_d;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  // Returns {known, row} for single-word opcodes; LDM is sequenced separately.
  function automatic logic [14:0] decode_row(input logic [OPCODE_W-1:0] op);
    logic [14:0] r;
    r = 15'd0;
    case (op)
      NOP_W:   r = {1'b1, 14'd0};
      NOT_W:   r = {1'b1, ROW_NOT};
      ADD_W:   r = {1'b1, ROW_ADD};
      STD_W:   r = {1'b1, ROW_STD};
      default: r = 15'd0;
    endcase
    return r;
  endfunction

  logic [14:0] dec;

  always_comb begin
    dec       = decode_row(bus.opcode);
    state_d   = state_q;
    row_d     = row_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    cap_d     = cap_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (bus.flush_in) begin
      state_d   = S_DECODE;
      row_d     = 14'd0;
      pend_d    = 14'd0;
      valid_d   = 1'b0;
      cap_d     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
    end else if (!bus.stall) begin
      row_d     = 14'd0;
      valid_d   = 1'b0;
      cap_d     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
      case (state_q)
        S_DECODE: begin
          if (bus.instr_valid) begin
            if (bus.opcode == LDM_W) begin
              pend_d  = ROW_LDM;
              state_d = S_IMM_WAIT;
            end else if (dec[14]) begin
              row_d   = dec[13:0];
              valid_d = 1'b1;
            end else begin
`ifdef ILLEGAL_TRAP_EN
              illegal_d = 1'b1;
              state_d   = S_TRAP;
`else
              valid_d   = 1'b1;
`endif
            end
          end
        end
        S_IMM_WAIT: begin
          // Word in decode is the immediate; it is never decoded as an opcode.
          if (bus.instr_valid) begin
            row_d   = pend_q;
            valid_d = 1'b1;
            cap_d   = 1'b1;
            pend_d  = 14'd0;
            state_d = S_DECODE;
          end
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: illegal_d = 1'b1;
`endif
        default: state_d = S_DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_DECODE;
      row_q     <= 14'd0;
      pend_q    <= 14'd0;
      valid_q   <= 1'b0;
      cap_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      cap_q     <= cap_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign bus.EX_signals  = row_q[13:7];
  assign bus.MEM_signals = row_q[6:3];
  assign bus.WB_signals  = row_q[2:0];
  assign bus.ctrl_valid  = valid_q;
  assign bus.imm_capture = cap_q;
  assign bus.imm_fetch   = (state_q == S_DECODE) && bus.instr_valid && (bus.opcode == LDM_W);
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_op  = illegal_q;
`else
  assign bus.illegal_op  = 1'b0;
`endif

endmodule
